// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Byte-stream program loader feeding the write port of the instruction
// memory.  A frame is SYNC_BYTE, LEN, LEN data bytes and (optionally) a
// checksum byte.  Data bytes are written sequentially from BASE_ADDR.  The
// CPU is held for the whole frame, and the outcome is reported at the end.
//
// Optional feature macro: IMEM_LOADER_CKSUM_EN
//   defined   -> a trailing checksum byte (mod-256 sum of the data) is
//                expected and checked; load_err reports a bad frame.
//   undefined -> frame ends after the last data byte; load_err is tied 0
//                and no running-sum logic exists.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   in_data      stream byte
//   in_valid     in_data valid
//   in_ready     loader accepts a byte this cycle
//   mem_we       instruction-memory write strobe
//   mem_addr     write address
//   mem_wdata    write data
//   cpu_hold     stall PC/writeback while high
//   load_done    one-cycle pulse, frame loaded (and checksum good)
//   load_err     sticky, last frame failed its checksum
//   words_loaded data bytes written by the current/last frame
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hA5,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  // Remaining-byte counter must hold both 2^DATA_W (LEN = 0) and 2^ADDR_W.
  localparam int               CNT_W     = ((DATA_W > ADDR_W) ? DATA_W : ADDR_W) + 1;
  localparam logic [CNT_W-1:0] FULL_LEN  = CNT_W'(1) << DATA_W;
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CKSUM,
    S_FINISH
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              accept;
  logic [CNT_W-1:0]  len_count;
  logic [CNT_W-1:0]  remaining;
  logic [ADDR_W-1:0] wr_addr;
  logic              mem_we_q;

`ifdef IMEM_LOADER_CKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              ok;
  logic              load_err_q;

  assign load_err = load_err_q;
`else
  assign load_err = 1'b0;
`endif

  assign in_ready = !rst && (state != S_FINISH);
  assign accept   = in_valid && in_ready;

  // A strobe registered just before reset must not reach the memory.
  assign mem_we = mem_we_q && !rst;

  // LEN byte to payload length: 0 means a full 2^DATA_W, clipped to memory size.
  always_comb begin
    len_count = (in_data == '0) ? FULL_LEN : CNT_W'(in_data);
    if (len_count > MAX_WORDS) begin
      len_count = MAX_WORDS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && (in_data == SYNC_BYTE)) begin
          state_next = S_LEN;
        end
      end
      S_LEN: begin
        if (accept) begin
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (remaining == CNT_W'(1))) begin
`ifdef IMEM_LOADER_CKSUM_EN
          state_next = S_CKSUM;
`else
          state_next = S_FINISH;
`endif
        end
      end
      S_CKSUM: begin
        if (accept) begin
          state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // load_done is registered on leaving FINISH, so it rises together with
  // the release of cpu_hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_q     <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      words_loaded <= '0;
      wr_addr      <= BASE_ADDR;
      remaining    <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      sum          <= '0;
      ok           <= 1'b0;
      load_err_q   <= 1'b0;
`endif
    end else begin
      mem_we_q  <= 1'b0;
      load_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && (in_data == SYNC_BYTE)) begin
            cpu_hold     <= 1'b1;
            words_loaded <= '0;
            wr_addr      <= BASE_ADDR;
            mem_addr     <= BASE_ADDR;
`ifdef IMEM_LOADER_CKSUM_EN
            sum          <= '0;
            load_err_q   <= 1'b0;
`endif
          end
        end
        S_LEN: begin
          if (accept) begin
            remaining <= len_count;
          end
        end
        S_DATA: begin
          if (accept) begin
            mem_we_q     <= 1'b1;
            mem_wdata    <= in_data;
            mem_addr     <= wr_addr;
            wr_addr      <= wr_addr + ADDR_W'(1);
            words_loaded <= words_loaded + (ADDR_W+1)'(1);
            remaining    <= remaining - CNT_W'(1);
`ifdef IMEM_LOADER_CKSUM_EN
            sum          <= sum + in_data;
`endif
          end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        S_CKSUM: begin
          if (accept) begin
            ok <= (in_data == sum);
          end
        end
`endif
        S_FINISH: begin
          cpu_hold <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
          load_done <= ok;
          if (!ok) begin
            load_err_q <= 1'b1;
          end
`else
          load_done <= 1'b1;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule
